// File: rtl/isq_pkg.sv
// ============================================================================
//  Module      : isq_pkg
//  Description : Shared constants, entry record and ROB-age compare for the
//                issue-queue age-select block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package isq_pkg;

  localparam int unsigned c_data_width    = 248;
  localparam int unsigned c_num_src       = 2;
  localparam int unsigned c_preg_width    = 6;
  localparam int unsigned c_depth         = 8;
  localparam int unsigned c_num_wakeup    = 2;
  localparam int unsigned c_rob_idx_width = 7;

  // One queue slot at the default widths
  typedef struct packed {
    logic                                  valid;
    logic [c_data_width-1:0]               data;
    logic [c_rob_idx_width-1:0]            rob_idx;
    logic [c_num_src*c_preg_width-1:0]     src_tag;
    logic [c_num_src-1:0]                  cond;
  } isq_entry_t;

  // True when the entry (e_*) is strictly younger than the boundary (f_*).
  // Low index parts are passed zero-extended so any ROB width up to 65 fits.
  function automatic logic rob_is_younger(input logic        e_wrap,
                                          input logic [63:0] e_low,
                                          input logic        f_wrap,
                                          input logic [63:0] f_low);
    return (e_wrap != f_wrap) ^ (e_low > f_low);
  endfunction

endpackage

`default_nettype wire

// File: rtl/isq_age_entry.sv
// ============================================================================
//  Module      : isq_age_entry
//  Description : One issue-queue slot: payload/tag storage, wakeup CAM with
//                enqueue bypass, sticky condition bits, flush kill compare
//                and ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module isq_age_entry
  import isq_pkg::*;
#(
  parameter int DATA_WIDTH    = c_data_width,
  parameter int NUM_SRC       = c_num_src,
  parameter int PREG_WIDTH    = c_preg_width,
  parameter int NUM_WAKEUP    = c_num_wakeup,
  parameter int ROB_IDX_WIDTH = c_rob_idx_width
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic [NUM_SRC*PREG_WIDTH-1:0] wr_src_tag,
  input  logic [NUM_SRC-1:0]            wr_src_rdy,
  input  logic [ROB_IDX_WIDTH-1:0]      wr_rob_idx,
  input  logic [NUM_WAKEUP-1:0]         wakeup_valid,
  input  logic [NUM_WAKEUP*PREG_WIDTH-1:0] wakeup_preg,
  input  logic                          free,
  input  logic                          flush_valid,
  input  logic [ROB_IDX_WIDTH-1:0]      flush_rob_idx,
  output logic                          valid,
  output logic                          ready,
  output logic [DATA_WIDTH-1:0]         data,
  output logic [ROB_IDX_WIDTH-1:0]      rob_idx
);

  localparam int c_low_w = ROB_IDX_WIDTH - 1;

  logic                          r_valid;
  logic [DATA_WIDTH-1:0]         r_data;
  logic [ROB_IDX_WIDTH-1:0]      r_rob_idx;
  logic [NUM_SRC*PREG_WIDTH-1:0] r_src_tag;
  logic [NUM_SRC-1:0]            r_cond;
  logic [NUM_SRC-1:0]            w_wake_hit;
  logic [NUM_SRC-1:0]            w_byp_hit;
  logic                          w_kill;

  // Tag CAM: stored tags for wakeup, incoming tags for the enqueue bypass
  always_comb begin
    w_wake_hit = '0;
    w_byp_hit  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int p = 0; p < NUM_WAKEUP; p++) begin
        if (wakeup_valid[p] &&
            wakeup_preg[p*PREG_WIDTH +: PREG_WIDTH] == r_src_tag[k*PREG_WIDTH +: PREG_WIDTH])
          w_wake_hit[k] = 1'b1;
        if (wakeup_valid[p] &&
            wakeup_preg[p*PREG_WIDTH +: PREG_WIDTH] == wr_src_tag[k*PREG_WIDTH +: PREG_WIDTH])
          w_byp_hit[k] = 1'b1;
      end
    end
  end

  assign w_kill = flush_valid && r_valid &&
                  rob_is_younger(r_rob_idx[ROB_IDX_WIDTH-1], 64'(r_rob_idx[c_low_w-1:0]),
                                 flush_rob_idx[ROB_IDX_WIDTH-1], 64'(flush_rob_idx[c_low_w-1:0]));

  // Slot state: write on enqueue, drop on issue/kill, otherwise accumulate wakeups
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_rob_idx <= '0;
      r_src_tag <= '0;
      r_cond    <= '0;
    end else if (wr_en) begin
      r_valid   <= 1'b1;
      r_data    <= wr_data;
      r_rob_idx <= wr_rob_idx;
      r_src_tag <= wr_src_tag;
      r_cond    <= wr_src_rdy | w_byp_hit;
    end else if (r_valid) begin
      if (free || w_kill)
        r_valid <= 1'b0;
      else
        r_cond  <= r_cond | w_wake_hit;
    end
  end

  assign valid   = r_valid;
  assign ready   = r_valid && (&r_cond);
  assign data    = r_data;
  assign rob_idx = r_rob_idx;

endmodule

`default_nettype wire

// File: rtl/isq_age_select.sv
// ============================================================================
//  Module      : isq_age_select
//  Description : DEPTH-entry issue queue with tag-broadcast wakeup, age-matrix
//                oldest-ready select and ROB-relative flush.
//                Optional: ISQ_PERF_CNT_EN adds occupancy and stall counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module isq_age_select
  import isq_pkg::*;
#(
  parameter int DATA_WIDTH    = c_data_width,
  parameter int NUM_SRC       = c_num_src,
  parameter int PREG_WIDTH    = c_preg_width,
  parameter int DEPTH         = c_depth,
  parameter int NUM_WAKEUP    = c_num_wakeup,
  parameter int ROB_IDX_WIDTH = c_rob_idx_width
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enq_valid,
  output logic                             enq_ready,
  input  logic [DATA_WIDTH-1:0]            enq_data,
  input  logic [NUM_SRC*PREG_WIDTH-1:0]    enq_src_tag,
  input  logic [NUM_SRC-1:0]               enq_src_rdy,
  input  logic [ROB_IDX_WIDTH-1:0]         enq_rob_idx,
  input  logic [NUM_WAKEUP-1:0]            wakeup_valid,
  input  logic [NUM_WAKEUP*PREG_WIDTH-1:0] wakeup_preg,
  output logic                             iss_valid,
  input  logic                             iss_ready,
  output logic [DATA_WIDTH-1:0]            iss_data,
  output logic [ROB_IDX_WIDTH-1:0]         iss_rob_idx,
  input  logic                             flush_valid,
  input  logic [ROB_IDX_WIDTH-1:0]         flush_rob_idx
`ifdef ISQ_PERF_CNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]       perf_occupancy,
  output logic [31:0]                      perf_stall_cnt
`endif
);

  localparam int c_idx_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH+1);
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  logic [DEPTH-1:0]         w_valid;
  logic [DEPTH-1:0]         w_ready;
  logic [DEPTH-1:0]         w_sel;
  logic [DATA_WIDTH-1:0]    w_ent_data [DEPTH];
  logic [ROB_IDX_WIDTH-1:0] w_ent_rob  [DEPTH];
  logic [DEPTH-1:0]         r_older    [DEPTH];
  logic [c_cnt_w-1:0]       w_count;
  logic [c_idx_w-1:0]       w_free_idx;
  logic [c_idx_w-1:0]       w_sel_idx;
  logic                     w_enq_fire;
  logic                     w_iss_fire;

  // Occupancy from registered valids and lowest-index free slot
  always_comb begin
    w_count    = '0;
    w_free_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      w_count = w_count + c_cnt_w'(w_valid[i]);
    for (int i = DEPTH-1; i >= 0; i--)
      if (!w_valid[i]) w_free_idx = c_idx_w'(i);
  end

  // Oldest-ready select: a ready entry wins when no ready entry is older
  always_comb begin
    w_sel     = '0;
    w_sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = w_ready[i] && ((r_older[i] & w_ready) == '0);
      if (w_sel[i]) w_sel_idx = c_idx_w'(i);
    end
  end

  assign enq_ready   = (w_count < c_full) && !flush_valid;
  assign iss_valid   = (|w_ready) && !flush_valid;
  assign iss_data    = w_ent_data[w_sel_idx];
  assign iss_rob_idx = w_ent_rob[w_sel_idx];
  assign w_enq_fire  = enq_valid && enq_ready;
  assign w_iss_fire  = iss_valid && iss_ready;

  // Age matrix: new row marks every live entry older, new column cleared
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
    end else if (w_enq_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (c_idx_w'(i) == w_free_idx)
          r_older[i] <= w_valid;
        else
          r_older[i][w_free_idx] <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    isq_age_entry #(
      .DATA_WIDTH    (DATA_WIDTH),
      .NUM_SRC       (NUM_SRC),
      .PREG_WIDTH    (PREG_WIDTH),
      .NUM_WAKEUP    (NUM_WAKEUP),
      .ROB_IDX_WIDTH (ROB_IDX_WIDTH)
    ) u_entry (
      .clock         (clock),
      .reset         (reset),
      .wr_en         (w_enq_fire && (w_free_idx == c_idx_w'(gi))),
      .wr_data       (enq_data),
      .wr_src_tag    (enq_src_tag),
      .wr_src_rdy    (enq_src_rdy),
      .wr_rob_idx    (enq_rob_idx),
      .wakeup_valid  (wakeup_valid),
      .wakeup_preg   (wakeup_preg),
      .free          (w_iss_fire && w_sel[gi]),
      .flush_valid   (flush_valid),
      .flush_rob_idx (flush_rob_idx),
      .valid         (w_valid[gi]),
      .ready         (w_ready[gi]),
      .data          (w_ent_data[gi]),
      .rob_idx       (w_ent_rob[gi])
    );
  end

`ifdef ISQ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles where dispatch offered but was refused
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (enq_valid && !enq_ready && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign perf_occupancy = w_count;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire
